// File: rtl/shift_exec_stage_pkg.sv
// rtl/shift_exec_stage_pkg.sv - shared op encodings, flag positions and carry helper
package shift_exec_stage_pkg;

  localparam int WIDTH = 16;

  typedef enum logic [1:0] {
    OP_LSH   = 2'b00,
    OP_LSHI  = 2'b01,
    OP_ASHU  = 2'b10,
    OP_ASHUI = 2'b11
  } shift_op_e;

  localparam int FLAG_C = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  // Last bit shifted out; right shifts only exist for logical ops with a negative amount.
  function automatic logic shift_carry(input logic [15:0] a, input logic [4:0] amt, input logic funct);
    logic [4:0] k;
    logic [4:0] idx;
    logic       c;
    c = 1'b0;
    if (!funct && amt[4]) begin
      k   = 5'd0 - amt;
      idx = k - 5'd1;
      c   = a[idx[3:0]];
    end else if (!amt[4] && amt != 5'd0) begin
      idx = 5'd16 - amt;
      c   = a[idx[3:0]];
    end
    return c;
  endfunction

endpackage

// File: rtl/shift_exec_stage_shifter.sv
// rtl/shift_exec_stage_shifter.sv - 16-bit shifter unit: signed-amount logical, left-only arithmetic
module shift_exec_stage_shifter (
  input  logic [15:0] a,
  input  logic [4:0]  b,
  input  logic        funct,
  output logic [15:0] result
);

  logic [4:0]  neg_b;
  logic [15:0] shl;
  logic [15:0] shr;

  assign neg_b = 5'd0 - b;
  assign shl   = a << b;
  assign shr   = a >> neg_b;

  // Arithmetic form keeps the sign bit and only ever shifts left.
  assign result = funct ? {a[15], shl[14:0]} : (b[4] ? shr : shl);

endmodule

// File: rtl/shift_exec_stage.sv
// rtl/shift_exec_stage.sv - 2-stage shift execute pipeline with valid/ready handshake
// Optional {C,Z,N} flag generation enabled by defining SHIFT_FLAGS_EN.
module shift_exec_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [4:0]       in_imm,
  input  logic [3:0]       in_wb_addr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_wb_addr,
  output logic [2:0]       out_flags
);

  import shift_exec_stage_pkg::*;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [4:0]       s1_amt;
  logic             s1_funct;
  logic [3:0]       s1_wb;

  logic             s2_advance;
  logic             accept;
  logic             imm_sel;
  logic             funct_dec;
  logic [WIDTH-1:0] sh_result;
  logic [2:0]       flags_next;
  logic             unused_b;

  assign s2_advance = !out_valid || out_ready;
  assign in_ready   = !s1_valid || s2_advance;
  assign accept     = in_valid && in_ready;

  assign imm_sel   = (in_op == OP_LSHI) || (in_op == OP_ASHUI);
  assign funct_dec = (in_op == OP_ASHU) || (in_op == OP_ASHUI);
  assign unused_b  = ^in_b[WIDTH-1:5];

  shift_exec_stage_shifter u_shifter (
    .a      (s1_a),
    .b      (s1_amt),
    .funct  (s1_funct),
    .result (sh_result)
  );

`ifdef SHIFT_FLAGS_EN
  always_comb begin
    flags_next         = '0;
    flags_next[FLAG_C] = shift_carry(s1_a, s1_amt, s1_funct);
    flags_next[FLAG_Z] = (sh_result == '0);
    flags_next[FLAG_N] = sh_result[WIDTH-1];
  end
`else
  assign flags_next = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      s1_a        <= '0;
      s1_amt      <= '0;
      s1_funct    <= 1'b0;
      s1_wb       <= '0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_wb_addr <= '0;
      out_flags   <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_a     <= in_a;
        s1_amt   <= imm_sel ? in_imm : in_b[4:0];
        s1_funct <= funct_dec;
        s1_wb    <= in_wb_addr;
      end else if (s2_advance) begin
        s1_valid <= 1'b0;
      end
      // Result registers only load on a real transfer so stalled outputs stay put.
      if (s2_advance) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_result  <= sh_result;
          out_wb_addr <= s1_wb;
          out_flags   <= flags_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_exec_stage.sv
// tb/tb_shift_exec_stage.sv - directed and randomized bench for shift_exec_stage
module tb_shift_exec_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [4:0]  in_imm;
  logic [3:0]  in_wb_addr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [3:0]  out_wb_addr;
  logic [2:0]  out_flags;

  typedef struct packed {
    logic [15:0] res;
    logic [2:0]  fl;
    logic [3:0]  wb;
  } exp_t;

  exp_t q[$];
  int   nvec = 0;
  int   nerr = 0;

  logic        s_ir;
  logic        s_ov;
  logic [15:0] s_res;
  logic [2:0]  s_fl;
  logic [3:0]  s_wb;

  always #5 clk = ~clk;

  shift_exec_stage #(.WIDTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_imm      (in_imm),
    .in_wb_addr  (in_wb_addr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_wb_addr (out_wb_addr),
    .out_flags   (out_flags)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t ref_model(input logic [1:0] op, input logic [15:0] a,
                                     input logic [15:0] b, input logic [4:0] imm,
                                     input logic [3:0] wb);
    exp_t   e;
    int     u;
    int     k;
    longint r;
    logic   c;
    u = op[0] ? int'(imm) : int'(b[4:0]);
    c = 1'b0;
    if (!op[1]) begin
      if (u < 16) begin
        r = (longint'(a) << u) & 64'hFFFF;
        if (u >= 1) c = a[16-u];
      end else begin
        k = 32 - u;
        r = longint'(a) >> k;
        c = a[k-1];
      end
    end else begin
      r = (longint'(a) & 64'h8000) | ((longint'(a) << u) & 64'h7FFF);
      if (u >= 1 && u <= 15) c = a[16-u];
    end
    e.res = r[15:0];
    e.wb  = wb;
`ifdef SHIFT_FLAGS_EN
    e.fl = {c, (r[15:0] == 16'h0), r[15]};
`else
    e.fl = 3'b000;
`endif
    return e;
  endfunction

  // One clock: drive, sample mid-cycle, score against the queue model, advance.
  task automatic cycle(input logic iv, input logic [1:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [4:0] imm, input logic [3:0] wb,
                       input logic ordy);
    logic exp_ir;
    in_valid = iv; in_op = op; in_a = a; in_b = b; in_imm = imm; in_wb_addr = wb;
    out_ready = ordy;
    #1;
    s_ir = in_ready; s_ov = out_valid; s_res = out_result; s_fl = out_flags; s_wb = out_wb_addr;
    exp_ir = (q.size() < 2) || ordy;
    check("in_ready", s_ir, exp_ir);
    if (q.size() == 0) check("idle_out_valid", s_ov, 1'b0);
    if (s_ov && q.size() > 0) begin
      check("result", s_res, q[0].res);
      check("flags", s_fl, q[0].fl);
      check("wb_addr", s_wb, q[0].wb);
      if (ordy) void'(q.pop_front());
    end
    if (iv && s_ir) q.push_back(ref_model(op, a, b, imm, wb));
    @(posedge clk);
    #1;
  endtask

  task automatic single(input string tag, input logic [1:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [4:0] imm,
                        input logic [15:0] exp_res, input logic [2:0] exp_fl);
    logic [2:0] f;
`ifdef SHIFT_FLAGS_EN
    f = exp_fl;
`else
    f = 3'b000;
`endif
    cycle(1'b1, op, a, b, imm, 4'd5, 1'b1);
    check({tag, "_accept"}, s_ir, 1'b1);
    cycle(1'b0, 2'b00, 16'h0, 16'h0, 5'd0, 4'd0, 1'b1);
    check({tag, "_early"}, s_ov, 1'b0);
    cycle(1'b0, 2'b00, 16'h0, 16'h0, 5'd0, 4'd0, 1'b1);
    check({tag, "_latency"}, s_ov, 1'b1);
    check({tag, "_res"}, s_res, exp_res);
    check({tag, "_flags"}, s_fl, f);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_out_result"}, out_result, 16'h0);
    check({tag, "_out_wb"}, out_wb_addr, 4'h0);
    check({tag, "_out_flags"}, out_flags, 3'b000);
    q.delete();
    reset = 1'b0;
    #1;
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_after_valid"}, out_valid, 1'b0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0;
    in_imm = '0; in_wb_addr = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    do_reset("reset");

    single("lsh_3",    2'b00, 16'h0001, 16'h0003, 5'd0,     16'h0008, 3'b000);
    single("lshi_m4",  2'b01, 16'hF000, 16'h0000, 5'b11100, 16'h0F00, 3'b000);
    single("ashu_1",   2'b10, 16'h8001, 16'h0001, 5'd0,     16'h8002, 3'b101);
    single("lsh_r16",  2'b00, 16'h8000, 16'h0010, 5'd0,     16'h0000, 3'b110);
    single("lsh_zero", 2'b00, 16'h1234, 16'h0000, 5'd0,     16'h1234, 3'b000);

    cycle(1'b1, 2'b00, 16'h0011, 16'h0001, 5'd0, 4'd1, 1'b0);
    check("stall_acc1", s_ir, 1'b1);
    cycle(1'b1, 2'b01, 16'h0022, 16'h0000, 5'd2, 4'd2, 1'b0);
    check("stall_acc2", s_ir, 1'b1);
    cycle(1'b1, 2'b10, 16'h0033, 16'h0003, 5'd0, 4'd3, 1'b0);
    check("stall_full", s_ir, 1'b0);
    check("stall_hold_valid", s_ov, 1'b1);
    cycle(1'b1, 2'b10, 16'h0033, 16'h0003, 5'd0, 4'd3, 1'b0);
    check("stall_full2", s_ir, 1'b0);
    check("stall_hold_res", s_res, 16'h0022);
    cycle(1'b1, 2'b10, 16'h0033, 16'h0003, 5'd0, 4'd3, 1'b1);
    check("resume_accept", s_ir, 1'b1);
    check("resume_head", s_res, 16'h0022);
    cycle(1'b0, 2'b00, 16'h0, 16'h0, 5'd0, 4'd0, 1'b1);
    check("resume_second", s_res, 16'h0088);
    cycle(1'b0, 2'b00, 16'h0, 16'h0, 5'd0, 4'd0, 1'b1);
    check("resume_third", s_res, 16'h0198);
    check("resume_third_valid", s_ov, 1'b1);

    cycle(1'b1, 2'b00, 16'hAAAA, 16'h0001, 5'd0, 4'd7, 1'b0);
    cycle(1'b1, 2'b00, 16'h5555, 16'h0002, 5'd0, 4'd8, 1'b0);
    do_reset("midreset");
    repeat (4) cycle(1'b0, 2'b00, 16'h0, 16'h0, 5'd0, 4'd0, 1'b1);

    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 9) < 7, 2'($urandom), 16'($urandom), 16'($urandom),
            5'($urandom), 4'($urandom), $urandom_range(0, 9) < 6);
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      cycle(1'b0, 2'b00, 16'h0, 16'h0, 5'd0, 4'd0, 1'b1);
    end
    check("drain_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
